ddio_in_deser: RTL and testbench
================================

# ddio_in_deser

Deserializer and word aligner for DDIO input pairs. It takes the per-pin high/low bit pairs produced by the DDIO input capture atoms (one pair per pin per clock) and assembles them into RATIO-bit words per pin. It provides per-lane bitslip and a training-pattern alignment state machine. It sits directly downstream of the DDIO input wrapper, in the same clock domain, and feeds the parallel receive datapath.

## Interface
- WIDTH, 8: number of DDIO pins (lanes).
- RATIO, 8: bits per lane per word. Even, 4..10.
- TRAIN_PATTERN, 8'hA5: RATIO-bit alignment word. The MSB is the earliest-in-time bit.
- clk  input  1: capture clock, the same clock as the DDIO atoms.
- areset  input  1: asynchronous, active-high reset.
- clkena  input  1: qualifies each datain pair. Low means hold all state.
- datain_h  input  WIDTH: high-register bit per lane. First in time.
- datain_l  input  WIDTH: low-register bit per lane. Second in time.
- align_start  input  1: one-cycle pulse that (re)starts training.
- dataout  output  WIDTH*RATIO: lane i occupies bits [i*RATIO +: RATIO], MSB earliest.
- dataout_valid  output  1: one-cycle word strobe.
- aligned  output  1: high while in LOCKED.
- align_fail  output  1: high while in FAIL.

## Operation
- Per lane, a 2*RATIO-bit shift register. On each enabled edge: sr <= {sr[2R-3:0], h, l}.
- Lane word = window[slip +: RATIO] of the post-shift value, with slip in 0..RATIO-1. Incrementing slip delays the word boundary by one bit (uses older bits).
- Phase counter counts 0..RATIO/2-1 on enabled edges.
  - At phase RATIO/2-1, dataout is loaded with all lane windows and dataout_valid = 1.
  - Otherwise dataout_valid = 0. dataout holds its value between strobes.
- Word strobes occur in every state. aligned marks when the data is trustworthy.
- FSM states: IDLE, TRAIN, LOCKED, FAIL.
  - IDLE, LOCKED or FAIL, on align_start: go to TRAIN. Clear all slip, ok and skip bits and the timeout counter.
  - align_start while in TRAIN: restart TRAIN with the same clearing.
  - TRAIN, per lane on each word strobe:
    - If skip is set: clear skip and ignore this word.
    - Else if ok is set: no change.
    - Else if the word equals TRAIN_PATTERN: set ok.
    - Else: slip <= (slip+1) mod RATIO and set skip.
  - TRAIN: the timeout counter increments per strobe.
    - All ok: go to LOCKED.
    - Otherwise, when the counter reaches 2*RATIO: go to FAIL.
    - If all ok and timeout happen on the same strobe, LOCKED wins.
  - LOCKED and FAIL: slips are frozen.
- Simultaneous align_start and word strobe: align_start wins, and that word is not evaluated.

## Timing
- dataout and dataout_valid are registered on the same edge that samples the final pair of a word, giving a latency of 1 clock from that pair.
- With clkena held at 1, dataout_valid pulses once every RATIO/2 clocks.
- clkena = 0: shift registers, phase counter, FSM and counters hold, and dataout_valid = 0.
- aligned and align_fail are registered. They change on the edge after the deciding strobe or after align_start.
- Reset values:
  - dataout = 0, dataout_valid = 0, aligned = 0, align_fail = 0.
  - State = IDLE; all slip, ok and skip = 0; phase = 0; shift registers = 0.
- Reset mid-operation aborts training immediately, with no completion.

## Structure
- Package ddio_deser_pkg holds:
  - the state enum (IDLE, TRAIN, LOCKED, FAIL);
  - RATIO legality checks;
  - the timeout constant function (2*RATIO).
- Sub-module ddio_deser_lane, instantiated WIDTH times. Each contains the shift register, slip window, pattern compare, and its slip, skip and ok registers.
- The top level holds the phase counter, FSM, timeout counter and output registers.

## Test plan
All scenarios use WIDTH=2, RATIO=8, TRAIN_PATTERN=8'hA5.
- Reset: assert areset mid-word during TRAIN. Required: all outputs 0 asynchronously, state IDLE. After release, the first strobe arrives 4 enabled clocks later.
- Raw capture, slip 0: drive pairs (1,0),(1,0),(0,1),(0,1) on both lanes. Required: dataout = 16'hA5A5 and a one-cycle valid on the edge sampling the 4th pair, repeating every 4 clocks.
- Training with lane 1 stream shifted to need slip=3 and lane 0 already aligned:
  - lane 0 ok on word 1;
  - lane 1 shows mismatch, skip, mismatch, skip, mismatch, skip, match;
  - required: aligned = 1 one cycle after the 7th strobe, and lane 1 dataout = 8'hA5 thereafter.
- No pattern, constant zeros: required align_fail = 1 after the 16th strobe, aligned = 0, lane slips wrapped through 0..7.
- clkena toggling 1,0,1,0: required valid every 8 clocks, with the same word values as in the continuous run.
- align_start while LOCKED: required aligned = 0 on the next edge, slips cleared, and re-lock after the pattern is seen.

Source files
------------

// File: rtl/ddio_deser_pkg.sv
// ddio_deser_pkg: alignment FSM states, RATIO legality check and training timeout shared by the DDIO deserializer
package ddio_deser_pkg;
  typedef enum logic [1:0] {IDLE, TRAIN, LOCKED, FAIL} state_t;
  function automatic bit ratio_ok(input int r);
    return r >= 4 && r <= 10 && r % 2 == 0;
  endfunction
  function automatic int timeout(input int r);
    return 2 * r;
  endfunction
endpackage

// File: rtl/ddio_deser_lane.sv
// ddio_deser_lane: one lane's 2*RATIO shift register, slip window, pattern compare and slip/skip/ok training state; clear restarts training, eval scores this strobe's word, word/ok out
module ddio_deser_lane
  import ddio_deser_pkg::*;
#(
  parameter int RATIO = 8,
  parameter logic [RATIO-1:0] TRAIN_PATTERN = 8'hA5
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             en,
  input  logic             h,
  input  logic             l,
  input  logic             clear,
  input  logic             eval,
  output logic [RATIO-1:0] word,
  output logic             ok
);
  localparam int SW = $clog2(RATIO);
  logic [2*RATIO-1:0] sr_q, sr_d;
  logic [SW-1:0] slip_q, slip_d;
  logic skip_q, skip_d, ok_q, ok_d, match, miss;
  always_comb begin
    sr_d = en ? {sr_q[2*RATIO-3:0], h, l} : sr_q;
    word = sr_d[slip_q +: RATIO];
    match = word == TRAIN_PATTERN;
    miss = eval && !skip_q && !ok_q && !match;
    slip_d = clear ? '0 : miss ? (slip_q == SW'(RATIO - 1) ? '0 : slip_q + 1'b1) : slip_q;
    skip_d = clear ? 1'b0 : eval ? miss : skip_q;
    ok_d = clear ? 1'b0 : ok_q || (eval && !skip_q && match);
  end
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      sr_q <= '0;
      slip_q <= '0;
      skip_q <= 1'b0;
      ok_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      slip_q <= slip_d;
      skip_q <= skip_d;
      ok_q <= ok_d;
    end
  assign ok = ok_q;
endmodule

// File: rtl/ddio_in_deser.sv
// ddio_in_deser: DDIO h/l pair deserializer with per-lane bitslip training; clk/areset/clkena, datain_h/l, align_start in; dataout, dataout_valid, aligned, align_fail out
module ddio_in_deser
  import ddio_deser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 8,
  parameter logic [RATIO-1:0] TRAIN_PATTERN = 8'hA5
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   clkena,
  input  logic [WIDTH-1:0]       datain_h,
  input  logic [WIDTH-1:0]       datain_l,
  input  logic                   align_start,
  output logic [WIDTH*RATIO-1:0] dataout,
  output logic                   dataout_valid,
  output logic                   aligned,
  output logic                   align_fail
);
  localparam int PW = $clog2(RATIO / 2);
  localparam int TW = $clog2(timeout(RATIO) + 1);
  if (!ratio_ok(RATIO)) begin : g_bad_ratio
    $error("RATIO must be even and within 4..10");
  end
  logic [PW-1:0] phase_q, phase_d;
  logic [TW-1:0] tmo_q, tmo_d;
  state_t state_q, state_d;
  logic [WIDTH*RATIO-1:0] dataout_q, dataout_d, words;
  logic valid_q, valid_d;
  logic [WIDTH-1:0] ok;
  logic strobe, eval;
  assign strobe = clkena && phase_q == PW'(RATIO / 2 - 1);
  // align_start on a strobe edge wins: the word is still output but never scored
  assign eval = strobe && !align_start && state_q == TRAIN;
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ddio_deser_lane #(.RATIO(RATIO), .TRAIN_PATTERN(TRAIN_PATTERN)) u_lane (
      .clk(clk),
      .areset(areset),
      .en(clkena),
      .h(datain_h[i]),
      .l(datain_l[i]),
      .clear(align_start),
      .eval(eval),
      .word(words[i*RATIO +: RATIO]),
      .ok(ok[i])
    );
  end
  // lane ok bits settle on the deciding strobe, so the FSM reacts one edge later; lock is checked before timeout
  always_comb begin
    phase_d = clkena ? (strobe ? '0 : phase_q + 1'b1) : phase_q;
    dataout_d = strobe ? words : dataout_q;
    valid_d = strobe;
    tmo_d = align_start ? '0 : eval ? tmo_q + 1'b1 : tmo_q;
    state_d = align_start ? TRAIN
            : state_q == TRAIN && &ok ? LOCKED
            : state_q == TRAIN && tmo_q == TW'(timeout(RATIO)) ? FAIL
            : state_q;
  end
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      phase_q <= '0;
      tmo_q <= '0;
      state_q <= IDLE;
      dataout_q <= '0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      tmo_q <= tmo_d;
      state_q <= state_d;
      dataout_q <= dataout_d;
      valid_q <= valid_d;
    end
  assign dataout = dataout_q;
  assign dataout_valid = valid_q;
  assign aligned = state_q == LOCKED;
  assign align_fail = state_q == FAIL;
endmodule

// File: tb/tb_ddio_in_deser.sv
// tb_ddio_in_deser: directed checks of capture, clkena hold, training lock/fail, relock and async reset
module tb_ddio_in_deser;
  import ddio_deser_pkg::*;
  logic clk = 1'b0;
  logic areset = 1'b1;
  logic clkena = 1'b0;
  logic align_start = 1'b0;
  logic [1:0] datain_h = '0;
  logic [1:0] datain_l = '0;
  logic [15:0] dataout;
  logic dataout_valid, aligned, align_fail;
  int tests = 0;
  int fails = 0;
  logic [7:0] lane1_tbl [7] = '{8'h2D, 8'h96, 8'h96, 8'h4B, 8'h4B, 8'hA5, 8'hA5};
  always #5 clk = ~clk;
  ddio_in_deser #(.WIDTH(2), .RATIO(8), .TRAIN_PATTERN(8'hA5)) u_dut (
    .clk(clk),
    .areset(areset),
    .clkena(clkena),
    .datain_h(datain_h),
    .datain_l(datain_l),
    .align_start(align_start),
    .dataout(dataout),
    .dataout_valid(dataout_valid),
    .aligned(aligned),
    .align_fail(align_fail)
  );
  task automatic pair(input logic [1:0] h, input logic [1:0] l, input logic st, input logic en);
    datain_h = h;
    datain_l = l;
    align_start = st;
    clkena = en;
    @(posedge clk);
    #1;
    align_start = 1'b0;
  endtask
  task automatic send(input logic [7:0] w0, input logic [7:0] w1, input int from, input int to, input int st);
    for (int j = from; j <= to; j++)
      pair({w1[7-2*j], w0[7-2*j]}, {w1[6-2*j], w0[6-2*j]}, j == st, 1'b1);
  endtask
  task automatic test_reset;
    tests++;
    if ({dataout, dataout_valid, aligned, align_fail} !== 19'd0) begin
      fails++;
      $display("FAIL reset_init: got %h want 0", {dataout, dataout_valid, aligned, align_fail});
    end
    areset = 1'b0;
    send(8'hA5, 8'h2D, 0, 3, 0);
    send(8'hA5, 8'h2D, 0, 3, -1);
    tests++;
    if (dataout !== 16'h96A5 || u_dut.state_q !== TRAIN) begin
      fails++;
      $display("FAIL reset_pretrain: got %h/%0d want 96a5/TRAIN", dataout, u_dut.state_q);
    end
    send(8'hA5, 8'h2D, 0, 1, -1);
    #3 areset = 1'b1;
    #1;
    tests++;
    if ({dataout, dataout_valid, aligned, align_fail} !== 19'd0 || u_dut.state_q !== IDLE) begin
      fails++;
      $display("FAIL reset_async: got %h state %0d want 0 IDLE", {dataout, dataout_valid, aligned, align_fail}, u_dut.state_q);
    end
    @(posedge clk);
    #1;
    areset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      send(8'hA5, 8'h2D, j, j, -1);
      tests++;
      if (dataout_valid !== (j == 3)) begin
        fails++;
        $display("FAIL reset_first_strobe pair %0d: valid %b want %b", j, dataout_valid, j == 3);
      end
    end
    tests++;
    if (dataout !== 16'h2DA5 || aligned !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_word: got %h aligned %b want 2da5 0", dataout, aligned);
    end
  endtask
  task automatic test_raw_capture;
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 4; j++) begin
        send(8'hA5, 8'hA5, j, j, -1);
        tests++;
        if (dataout_valid !== (j == 3)) begin
          fails++;
          $display("FAIL raw_valid w%0d p%0d: got %b want %b", w, j, dataout_valid, j == 3);
        end
        if (j == 3 || w > 0) begin
          tests++;
          if (dataout !== 16'hA5A5) begin
            fails++;
            $display("FAIL raw_data w%0d p%0d: got %h want a5a5", w, j, dataout);
          end
        end
      end
  endtask
  task automatic test_clkena;
    int cyc = 0;
    int last = -1;
    for (int w = 0; w < 2; w++)
      for (int j = 0; j < 4; j++) begin
        send(8'hA5, 8'h2D, j, j, -1);
        cyc++;
        tests++;
        if (dataout_valid !== (j == 3)) begin
          fails++;
          $display("FAIL clkena_valid w%0d p%0d: got %b want %b", w, j, dataout_valid, j == 3);
        end
        if (j == 3) begin
          tests++;
          if (dataout !== 16'h2DA5 || (last >= 0 && cyc - last != 8)) begin
            fails++;
            $display("FAIL clkena_word w%0d: got %h gap %0d want 2da5 gap 8", w, dataout, cyc - last);
          end
          last = cyc;
        end
        pair(~datain_h, ~datain_l, 1'b0, 1'b0);
        cyc++;
        tests++;
        if (dataout_valid !== 1'b0 || (j == 3 && dataout !== 16'h2DA5)) begin
          fails++;
          $display("FAIL clkena_hold w%0d p%0d: valid %b data %h want 0 2da5", w, j, dataout_valid, dataout);
        end
      end
  endtask
  task automatic train_run(input string name);
    for (int k = 0; k < 7; k++) begin
      send(8'hA5, 8'h2D, 0, 3, -1);
      tests++;
      if (dataout_valid !== 1'b1 || dataout !== {lane1_tbl[k], 8'hA5} || aligned !== 1'b0) begin
        fails++;
        $display("FAIL %s strobe %0d: valid %b data %h aligned %b want 1 %h 0", name, k + 1, dataout_valid, dataout, aligned, {lane1_tbl[k], 8'hA5});
      end
    end
    send(8'hA5, 8'h2D, 0, 0, -1);
    tests++;
    if (aligned !== 1'b1 || align_fail !== 1'b0) begin
      fails++;
      $display("FAIL %s lock: aligned %b fail %b want 1 0", name, aligned, align_fail);
    end
    send(8'hA5, 8'h2D, 1, 3, -1);
    tests++;
    if (dataout !== 16'hA5A5 || aligned !== 1'b1) begin
      fails++;
      $display("FAIL %s locked_word: got %h aligned %b want a5a5 1", name, dataout, aligned);
    end
  endtask
  task automatic test_train;
    send(8'hA5, 8'h2D, 0, 0, 0);
    tests++;
    if (u_dut.state_q !== TRAIN || aligned !== 1'b0) begin
      fails++;
      $display("FAIL train_start: state %0d want TRAIN", u_dut.state_q);
    end
    send(8'hA5, 8'h2D, 1, 3, -1);
    tests++;
    if (dataout !== 16'h2DA5) begin
      fails++;
      $display("FAIL train_strobe 1: got %h want 2da5", dataout);
    end
    for (int k = 1; k < 7; k++) begin
      send(8'hA5, 8'h2D, 0, 3, -1);
      tests++;
      if (dataout !== {lane1_tbl[k], 8'hA5} || aligned !== 1'b0) begin
        fails++;
        $display("FAIL train_strobe %0d: got %h aligned %b want %h 0", k + 1, dataout, aligned, {lane1_tbl[k], 8'hA5});
      end
    end
    send(8'hA5, 8'h2D, 0, 0, -1);
    tests++;
    if (aligned !== 1'b1) begin
      fails++;
      $display("FAIL train_lock: aligned %b want 1", aligned);
    end
    send(8'hA5, 8'h2D, 1, 3, -1);
    tests++;
    if (dataout !== 16'hA5A5) begin
      fails++;
      $display("FAIL train_locked_word: got %h want a5a5", dataout);
    end
  endtask
  task automatic test_relock;
    send(8'hA5, 8'h2D, 0, 3, 3);
    tests++;
    if (dataout_valid !== 1'b1 || dataout !== 16'hA5A5 || aligned !== 1'b0 || u_dut.state_q !== TRAIN) begin
      fails++;
      $display("FAIL relock_start: valid %b data %h aligned %b want 1 a5a5 0", dataout_valid, dataout, aligned);
    end
    train_run("relock");
  endtask
  task automatic test_fail;
    for (int k = 0; k < 16; k++) begin
      send(8'h00, 8'h00, 0, 3, k == 0 ? 0 : -1);
      if (k == 7) begin
        tests++;
        if (u_dut.g_lane[0].u_lane.slip_q !== 3'd4 || u_dut.g_lane[1].u_lane.slip_q !== 3'd4) begin
          fails++;
          $display("FAIL fail_slip_mid: got %0d %0d want 4 4", u_dut.g_lane[0].u_lane.slip_q, u_dut.g_lane[1].u_lane.slip_q);
        end
      end
    end
    tests++;
    if (align_fail !== 1'b0 || dataout !== 16'h0000 || u_dut.g_lane[1].u_lane.slip_q !== 3'd0) begin
      fails++;
      $display("FAIL fail_strobe16: fail %b data %h slip %0d want 0 0000 0", align_fail, dataout, u_dut.g_lane[1].u_lane.slip_q);
    end
    send(8'h00, 8'h00, 0, 0, -1);
    tests++;
    if (align_fail !== 1'b1 || aligned !== 1'b0) begin
      fails++;
      $display("FAIL fail_state: fail %b aligned %b want 1 0", align_fail, aligned);
    end
    send(8'h00, 8'h00, 1, 3, -1);
    send(8'hA5, 8'h2D, 0, 3, -1);
    tests++;
    if (align_fail !== 1'b1 || u_dut.g_lane[1].u_lane.slip_q !== 3'd0 || dataout !== 16'h2DA5) begin
      fails++;
      $display("FAIL fail_frozen: fail %b slip %0d data %h want 1 0 2da5", align_fail, u_dut.g_lane[1].u_lane.slip_q, dataout);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_raw_capture();
    test_clkena();
    test_train();
    test_relock();
    test_fail();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
